ins_refill_ctrl: RTL

//  Instruction-cache refill controller. Sits between the ISA cache and the DDR3 interface top.
//  On a cache miss it issues one instruction burst request (ins_read_req/addr/len).
//  It then pops the {ins, rd_cnt_ins, valid} words from the DDR-to-IC FIFO and writes them into the cache RAM.
//  It signals completion to the cache, or an error.

---
 rtl/ins_refill_ctrl_if.sv | 24 ++
 rtl/ins_refill_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ins_refill_ctrl_if.sv
// DDR-side channel of the instruction refill controller: burst request plus
// the DDR-to-IC FIFO pop interface.
interface ins_refill_ctrl_if #(
    parameter int unsigned DDR_ADDR_WIDTH = 28,
    parameter int unsigned ISA_WIDTH      = 30
);
    logic                      ins_read_req;
    logic [DDR_ADDR_WIDTH-1:0] ins_read_addr;
    logic [7:0]                ins_read_len;
    logic                      ins_reading;
    logic [ISA_WIDTH+8:0]      fifo_dout;
    logic                      fifo_empty;
    logic                      fifo_rd_en;

    modport master (
        output ins_read_req, ins_read_addr, ins_read_len, fifo_rd_en,
        input  ins_reading, fifo_dout, fifo_empty
    );

    modport slave (
        input  ins_read_req, ins_read_addr, ins_read_len, fifo_rd_en,
        output ins_reading, fifo_dout, fifo_empty
    );
endinterface

// File: rtl/ins_refill_ctrl.sv
// Instruction-cache refill controller: one DDR burst request per miss, then
// drains {ins, cnt, valid} words from the DDR-to-IC FIFO into the cache RAM.
module ins_refill_ctrl #(
    parameter int unsigned DDR_ADDR_WIDTH  = 28,
    parameter int unsigned ISA_WIDTH       = 30,
    parameter int unsigned CACHE_AW        = 7,
    parameter int unsigned REFILL_LEN      = 72,
    parameter int unsigned TOTAL_ISA_DEPTH = 128,
    parameter int unsigned TIMEOUT         = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      miss_req,
    input  logic [DDR_ADDR_WIDTH-1:0] miss_addr,
    output logic                      refill_busy,
    output logic                      refill_done,
    output logic                      refill_err,
    output logic [DDR_ADDR_WIDTH-1:0] base_addr,
    ins_refill_ctrl_if.master         ddr,
    output logic                      cache_wr_en,
    output logic [CACHE_AW-1:0]       cache_wr_addr,
    output logic [ISA_WIDTH-1:0]      cache_wr_data
);
    localparam int unsigned LW = DDR_ADDR_WIDTH + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] TOTAL_W  = LW'(TOTAL_ISA_DEPTH);
    localparam logic [LW-1:0] RLEN_W   = LW'(REFILL_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_DRAIN, S_DONE, S_ERR
    } state_t;

    state_t                    r_state, w_next;
    logic [DDR_ADDR_WIDTH-1:0] r_base;
    logic [7:0]                r_len;
    logic [7:0]                r_wr_cnt;
    logic [TW-1:0]             r_tmo;
    logic                      r_pending;
    logic                      r_wr_en;
    logic [CACHE_AW-1:0]       r_wr_addr;
    logic [ISA_WIDTH-1:0]      r_wr_data;

    logic [LW-1:0]             w_remain;
    logic [LW-1:0]             w_len_full;
    logic                      w_legal;
    logic                      w_rd_en;
    logic                      w_wr;
    logic                      w_valid;
    logic [7:0]                w_cnt;
    logic [ISA_WIDTH-1:0]      w_ins;

    // Length is clipped at the end of DDR instruction space, computed one bit wider.
    assign w_remain   = TOTAL_W - {1'b0, miss_addr};
    assign w_legal    = {1'b0, miss_addr} < TOTAL_W;
    assign w_len_full = (w_remain < RLEN_W) ? w_remain : RLEN_W;

    assign w_valid = ddr.fifo_dout[0];
    assign w_cnt   = ddr.fifo_dout[8:1];
    assign w_ins   = ddr.fifo_dout[ISA_WIDTH+8:9];

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        w_wr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (miss_req) w_next = w_legal ? S_REQ : S_ERR;
            end
            S_REQ: begin
                if (ddr.ins_reading)        w_next = S_DRAIN;
                else if (r_tmo == TMO_LAST) w_next = S_ERR;
            end
            S_DRAIN: begin
                // At most one pop in flight; its data is judged the following cycle.
                w_rd_en = !ddr.fifo_empty && !r_pending && (r_wr_cnt < r_len);
                w_wr    = r_pending && w_valid && (w_cnt < r_len);
                if (r_wr_cnt == r_len)                           w_next = S_DONE;
                else if (r_pending && w_valid && w_cnt >= r_len) w_next = S_ERR;
                else if (!w_wr && r_tmo == TMO_LAST)             w_next = S_ERR;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_len     <= '0;
            r_wr_cnt  <= '0;
            r_tmo     <= '0;
            r_pending <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_next;
            r_pending <= w_rd_en;
            r_wr_en   <= w_wr;
            if (r_state == S_IDLE && miss_req && w_legal) begin
                r_base <= miss_addr;
                r_len  <= w_len_full[7:0];
            end
            if (r_state == S_IDLE) r_wr_cnt <= '0;
            else if (w_wr)         r_wr_cnt <= r_wr_cnt + 8'd1;
            if (w_wr) begin
                r_wr_addr <= w_cnt[CACHE_AW-1:0];
                r_wr_data <= w_ins;
            end
            // Timer restarts on every state entry and every accepted word.
            if (w_next != r_state || w_wr || !(r_state inside {S_REQ, S_DRAIN}))
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + 1'b1;
        end
    end

    assign refill_busy       = (r_state != S_IDLE);
    assign refill_done       = (r_state == S_DONE);
    assign refill_err        = (r_state == S_ERR);
    assign base_addr         = r_base;
    assign ddr.ins_read_req  = (r_state == S_REQ);
    assign ddr.ins_read_addr = r_base;
    assign ddr.ins_read_len  = r_len;
    assign ddr.fifo_rd_en    = w_rd_en;
    assign cache_wr_en       = r_wr_en;
    assign cache_wr_addr     = r_wr_addr;
    assign cache_wr_data     = r_wr_data;
endmodule
